// File: rtl/halfadd_accum.sv
// Accumulates a stream of 2-bit half-adder results {C,S} over a fixed number of samples.
// Optional macro ACC_SAT_EN makes an overflowing add saturate instead of wrapping.
module halfadd_accum #(
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4,
    localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             in_valid,
    input  logic             C,
    input  logic             S,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic             clear;
    logic             accept;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;

    // One extra bit on the left captures the carry out of the accumulator.
    assign sum = {1'b0, acc_out} + {{(ACC_W-1){1'b0}}, C, S};

`ifdef ACC_SAT_EN
    // Once saturated, the total stays pinned at full scale until the next start.
    assign acc_nxt = (sum[ACC_W] || ovf) ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    assign in_ready = (state_q == ACCUM);
    assign done     = (state_q == DONE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        clear   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (count == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q <= IDLE;
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                acc_out <= '0;
                count   <= '0;
                ovf     <= 1'b0;
            end else if (accept) begin
                acc_out <= acc_nxt;
                count   <= count + CNT_W'(1);
                ovf     <= ovf | sum[ACC_W];
            end
        end
    end

endmodule
